// File: rtl/object_draw_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : object_draw_ctrl
//  Description : Streams a 16x16 24-bit sprite from the object ROM into the
//                VGA pixel-write port. It can also erase the sprite footprint
//                with a background colour. Transparent texels are skipped
//                and off-screen pixels are clipped.
//  Revision    : 1.0 - initial release
// ============================================================================
module object_draw_ctrl #(
    parameter int          XSCREEN     = 160,
    parameter int          YSCREEN     = 120,
    parameter int          X_W         = 8,
    parameter int          Y_W         = 7,
    parameter logic [23:0] TRANSPARENT = 24'h000000
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic           erase,
    input  logic [X_W-1:0] x0,
    input  logic [Y_W-1:0] y0,
    input  logic [23:0]    bg_color,
    output logic [7:0]     rom_addr,
    input  logic [23:0]    rom_q,
    output logic [X_W-1:0] vga_x,
    output logic [Y_W-1:0] vga_y,
    output logic [23:0]    vga_color,
    output logic           vga_write,
    output logic           busy,
    output logic           done
);

    localparam logic [X_W:0] c_xscreen = (X_W+1)'(XSCREEN);
    localparam logic [Y_W:0] c_yscreen = (Y_W+1)'(YSCREEN);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [7:0]      r_cnt;
    logic [7:0]      r_pix;
    logic [X_W-1:0]  r_x0;
    logic [Y_W-1:0]  r_y0;
    logic            r_erase;
    logic [23:0]     r_bg;

    logic [X_W:0]    w_px;
    logic [Y_W:0]    w_py;
    logic            w_in_bounds;
    logic            w_write;

    // One extra bit on each coordinate keeps right/bottom overflow visible
    // to the bounds compare instead of wrapping back on-screen.
    assign w_px        = (X_W+1)'(r_x0) + (X_W+1)'(r_pix[3:0]);
    assign w_py        = (Y_W+1)'(r_y0) + (Y_W+1)'(r_pix[7:4]);
    assign w_in_bounds = (w_px < c_xscreen) && (w_py < c_yscreen);
    assign w_write     = w_in_bounds && (r_erase || (rom_q != TRANSPARENT));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The ROM address runs one ahead of the pixel being processed, which
    // covers the one-cycle ROM read latency.
    always_comb begin
        w_state_next = r_state;
        rom_addr     = 8'd0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                rom_addr = r_cnt;
                if (r_pix == 8'hFF) begin
                    w_state_next = FINISH;
                end
            end
            FINISH: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt     <= 8'd0;
            r_pix     <= 8'd0;
            r_x0      <= '0;
            r_y0      <= '0;
            r_erase   <= 1'b0;
            r_bg      <= 24'd0;
            vga_x     <= '0;
            vga_y     <= '0;
            vga_color <= 24'd0;
            vga_write <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            vga_write <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_x0    <= x0;
                        r_y0    <= y0;
                        r_erase <= erase;
                        r_bg    <= bg_color;
                        r_cnt   <= 8'd1;
                        r_pix   <= 8'd0;
                    end
                end
                RUN: begin
                    r_cnt     <= r_cnt + 8'd1;
                    r_pix     <= r_pix + 8'd1;
                    vga_x     <= w_px[X_W-1:0];
                    vga_y     <= w_py[Y_W-1:0];
                    vga_color <= r_erase ? r_bg : rom_q;
                    vga_write <= w_write;
                    busy      <= 1'b1;
                end
                FINISH: begin
                    done <= 1'b1;
                end
                default: begin
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
